// File: rtl/ififo_pkg.sv
// Core types shared between fetch, the instruction FIFO and dispatch.
// One FIFO entry is a fetched instruction plus its branch prediction.
package ififo_pkg;

  localparam int IFIFO_DEPTH     = 8;
  localparam int IFIFO_AF_THRESH = 6;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
    logic   is_cond_br;
    logic   br_dir_pred;
    addr_t  br_target_pred;
  } ififo_entry_t;

endpackage

// File: rtl/ififo_if.sv
// Fetch-side and dispatch-side handshake of the instruction FIFO.
// master = surrounding pipeline (fetch + decode), slave = the FIFO.
interface ififo_if import ififo_pkg::*; #(
  parameter int DEPTH = IFIFO_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic         fetch_valid;
  ififo_entry_t fetch_data;
  logic         fetch_ready;
  logic         fetch_almost_full;
  logic         ififo_dispatch_valid;
  ififo_entry_t ififo_dispatch_data;
  logic         ififo_dispatch_ready;
  logic [CW-1:0] count;

  modport master (
    output fetch_valid, fetch_data, ififo_dispatch_ready,
    input  fetch_ready, fetch_almost_full, ififo_dispatch_valid,
           ififo_dispatch_data, count
  );

  modport slave (
    input  fetch_valid, fetch_data, ififo_dispatch_ready,
    output fetch_ready, fetch_almost_full, ififo_dispatch_valid,
           ififo_dispatch_data, count
  );

endinterface

// File: rtl/ififo_fifo_ptr.sv
// Wrap-bit FIFO pointer: index in the low bits, lap parity in the MSB.
// Wrap-around is plain overflow of the register.
module ififo_fifo_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_aL,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH):0]   ptr
);

  localparam int PW = $clog2(DEPTH) + 1;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ififo.sv
// Instruction FIFO between fetch and decode: flip-flop storage, first-word
// fall-through head, no fetch-to-dispatch bypass, flush drops everything.
module ififo import ififo_pkg::*; #(
  parameter int DEPTH              = IFIFO_DEPTH,
  parameter int ALMOST_FULL_THRESH = IFIFO_AF_THRESH
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic flush,
  ififo_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] AF_T    = PW'(ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          enq;
  logic          deq;
  ififo_entry_t  mem [DEPTH];

  ififo_fifo_ptr #(.DEPTH(DEPTH)) u_head (
    .clk    (clk),
    .rst_aL (rst_aL),
    .clr    (flush),
    .inc    (deq),
    .ptr    (head)
  );

  ififo_fifo_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk    (clk),
    .rst_aL (rst_aL),
    .clr    (flush),
    .inc    (enq),
    .ptr    (tail)
  );

  assign empty = (head == tail);
  assign full  = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);

  // Ready depends only on state, so a full FIFO refuses even on a same-cycle dequeue.
  assign bus.fetch_ready          = !full;
  assign enq                      = bus.fetch_valid && !full;
  assign bus.ififo_dispatch_valid = !empty;
  assign deq                      = !empty && bus.ififo_dispatch_ready;
  assign bus.ififo_dispatch_data  = mem[head[IW-1:0]];
  assign bus.fetch_almost_full    = (count_q >= AF_T);
  assign bus.count                = count_q;

  // Storage stage: writes are dropped during flush; contents are otherwise kept.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq && !flush) begin
      mem[tail[IW-1:0]] <= bus.fetch_data;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (enq && !deq) begin
      count_q <= count_q + PW'(1);
    end else if (deq && !enq) begin
      count_q <= count_q - PW'(1);
    end
  end

  a_no_enq_full:  assert property (@(posedge clk) disable iff (!rst_aL) !(enq && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst_aL) !(deq && empty));
  a_count_range:  assert property (@(posedge clk) disable iff (!rst_aL) count_q <= DEPTH_C);
  a_count_ptrs:   assert property (@(posedge clk) disable iff (!rst_aL) count_q == (tail - head));

endmodule

// File: tb/tb_ififo.sv
// Self-checking bench for ififo: directed scenarios plus random traffic,
// compared against a queue-based reference of the FIFO behaviour.
module tb_ififo;
  import ififo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic clk;
  logic rst_aL;
  logic flush;

  ififo_if #(.DEPTH(DEPTH)) bus ();

  ififo #(.DEPTH(DEPTH), .ALMOST_FULL_THRESH(AF)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ififo_entry_t q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         last_enq;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ififo_entry_t mk(input logic [31:0] pc);
    ififo_entry_t e;
    e.instr          = $urandom;
    e.pc             = pc;
    e.is_cond_br     = 1'($urandom_range(0, 1));
    e.br_dir_pred    = 1'($urandom_range(0, 1));
    e.br_target_pred = $urandom;
    return e;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ":count"}, 128'(bus.count), 128'(q.size()));
    check_eq({tag, ":valid"}, 128'(bus.ififo_dispatch_valid), 128'(q.size() != 0));
    check_eq({tag, ":ready"}, 128'(bus.fetch_ready), 128'(q.size() < DEPTH));
    check_eq({tag, ":afull"}, 128'(bus.fetch_almost_full), 128'(q.size() >= AF));
    if (q.size() != 0)
      check_eq({tag, ":data"}, 128'(bus.ififo_dispatch_data), 128'(q[0]));
  endtask

  // Called 1 time unit after a rising edge; drives one cycle and checks after the next edge.
  task automatic cyc(input logic fv, input ififo_entry_t fd, input logic dr, input logic fl,
                     input string tag);
    logic m_enq, m_deq;
    bus.fetch_valid          = fv;
    bus.fetch_data           = fd;
    bus.ififo_dispatch_ready = dr;
    flush                    = fl;
    m_enq = fv && (q.size() < DEPTH);
    m_deq = dr && (q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (m_deq) void'(q.pop_front());
      if (m_enq) q.push_back(fd);
    end
    last_enq = m_enq && !fl;
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++)
      if (q.size() != 0) cyc(1'b0, '0, 1'b1, 1'b0, tag);
    check_eq({tag, ":empty"}, 128'(bus.ififo_dispatch_valid), 128'(0));
  endtask

  initial begin
    ififo_entry_t e;
    ififo_entry_t pend;
    logic         have_pend;
    int           pr;

    rst_aL = 1'b0;
    flush  = 1'b0;
    bus.fetch_valid          = 1'b0;
    bus.fetch_data           = '0;
    bus.ififo_dispatch_ready = 1'b0;
    last_enq = 1'b0;

    // Reset state
    #3;
    check_eq("rst:valid", 128'(bus.ififo_dispatch_valid), 128'(0));
    check_eq("rst:data",  128'(bus.ififo_dispatch_data),  128'(0));
    check_eq("rst:ready", 128'(bus.fetch_ready),          128'(1));
    check_eq("rst:afull", 128'(bus.fetch_almost_full),    128'(0));
    check_eq("rst:count", 128'(bus.count),                128'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_aL = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst");

    // Three enqueues, dispatch stalled
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b0, 1'b0, "enq3");
    check_eq("enq3:count3", 128'(bus.count), 128'(3));
    check_eq("enq3:head_pc", 128'(bus.ififo_dispatch_data.pc), 128'(32'h1000));
    check_eq("enq3:ready1", 128'(bus.fetch_ready), 128'(1));

    // Fill to DEPTH, then a refused ninth offer
    for (int i = 3; i < DEPTH; i++) begin
      cyc(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b0, 1'b0, "fill");
      check_eq("fill:afull_const", 128'(bus.fetch_almost_full), 128'(i + 1 >= AF));
    end
    check_eq("full:ready0", 128'(bus.fetch_ready), 128'(0));
    cyc(1'b1, mk(32'h1020), 1'b0, 1'b0, "ninth");
    check_eq("ninth:count8", 128'(bus.count), 128'(8));
    check_eq("ninth:head_pc", 128'(bus.ififo_dispatch_data.pc), 128'(32'h1000));

    // Full with simultaneous offer and dequeue: only the dequeue happens
    e = mk(32'h2000);
    cyc(1'b1, e, 1'b1, 1'b0, "full_deq");
    check_eq("full_deq:count7", 128'(bus.count), 128'(7));
    cyc(1'b1, e, 1'b0, 1'b0, "full_retry");
    check_eq("full_retry:count8", 128'(bus.count), 128'(8));
    drain("drain1");

    // Streaming 20 entries, enqueue and dequeue every cycle
    for (int i = 0; i < 20; i++) begin
      if (i > 0)
        check_eq("stream:pc", 128'(bus.ififo_dispatch_data.pc), 128'(32'h1000 + 32'(4 * (i - 1))));
      cyc(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b1, 1'b0, "stream");
      check_eq("stream:count1", 128'(bus.count), 128'(1));
    end
    drain("drain2");

    // Flush at count 5 together with an offer and a dequeue
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'h2100 + 32'(4 * i)), 1'b0, 1'b0, "pre_flush");
    cyc(1'b1, mk(32'h3000), 1'b1, 1'b1, "flush");
    check_eq("flush:count0", 128'(bus.count), 128'(0));
    check_eq("flush:valid0", 128'(bus.ififo_dispatch_valid), 128'(0));
    cyc(1'b0, '0, 1'b0, 1'b0, "post_flush");
    check_eq("post_flush:valid0", 128'(bus.ififo_dispatch_valid), 128'(0));

    // Asynchronous reset pulse mid-cycle at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(32'h2200 + 32'(4 * i)), 1'b0, 1'b0, "pre_arst");
    bus.fetch_valid = 1'b0;
    #2 rst_aL = 1'b0;
    #1;
    check_eq("arst:valid0", 128'(bus.ififo_dispatch_valid), 128'(0));
    check_eq("arst:count0", 128'(bus.count), 128'(0));
    check_eq("arst:data0",  128'(bus.ififo_dispatch_data), 128'(0));
    q.delete();
    #1 rst_aL = 1'b1;
    @(posedge clk);
    #1;
    e = mk(32'h4000);
    cyc(1'b1, e, 1'b0, 1'b0, "after_arst");
    check_eq("after_arst:head_pc", 128'(bus.ififo_dispatch_data.pc), 128'(32'h4000));
    drain("drain3");

    // Random traffic in phases of different dispatch pressure
    have_pend = 1'b0;
    pend      = '0;
    for (int seg = 0; seg < 4; seg++) begin
      pr = (seg == 0) ? 20 : (seg == 1) ? 85 : (seg == 2) ? 50 : 95;
      for (int c = 0; c < 100; c++) begin
        if (!have_pend && $urandom_range(0, 3) != 0) begin
          pend      = mk($urandom);
          have_pend = 1'b1;
        end
        cyc(have_pend, pend, $urandom_range(0, 99) < pr, $urandom_range(0, 29) == 0, "rand");
        if (last_enq) have_pend = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
